apb_bus_arbiter: RTL and testbench

- Two-requester arbiter that shares the single APB master's internal bus interface (transfer/ready/write/addr/wdata/rdata).
- Requester 0 is the RV32I core's data bus; requester 1 is a second bus master such as a DMA or UART loader.
- Sits between the requesters and the APB master.
- Sequences one transfer at a time with round-robin fairness and a ready-timeout watchdog.

---
 rtl/apb_bus_arbiter.sv | 115 +++++++++++
 tb/tb_apb_bus_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// Two-requester arbiter in front of a single APB master: round-robin grant,
// request fields captured at grant, and a ready watchdog that forces completion.
module apb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        m0_transfer,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    input  logic        m1_transfer,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        transfer,
    output logic        write,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    input  logic [31:0] rdata,
    input  logic        ready,
    output logic [1:0]  grant,
    output logic        timeout_err
);
    // state | meaning
    // IDLE  | nothing outstanding; arbitrate, late ready ignored
    // ISSUE | one-cycle transfer pulse; ready already counts as completion
    // WAIT  | waiting for ready or watchdog expiry
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [1:0]       r_state;
    logic             r_last;
    logic [CNT_W-1:0] r_cnt;
    logic             r_write;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [1:0]       r_grant;

    logic             w_busy;
    logic             w_any_req;
    logic             w_sel1;
    logic             w_timeout;
    logic             w_done;
    logic [31:0]      w_resp;

    assign w_busy    = (r_state != S_IDLE);
    assign w_any_req = m0_transfer | m1_transfer;
    // m1 wins when alone, or on a tie when m0 was served last
    assign w_sel1    = m1_transfer & (~m0_transfer | ~r_last);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_busy && (r_cnt == CNT_LIMIT) && !ready;
    assign w_done    = w_busy & (ready | w_timeout);
    assign w_resp    = ready ? rdata : ERR_RDATA;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_ISSUE;
                        r_last  <= w_sel1;
                        r_grant <= w_sel1 ? 2'b10 : 2'b01;
                        r_write <= w_sel1 ? m1_write : m0_write;
                        r_addr  <= w_sel1 ? m1_addr  : m0_addr;
                        r_wdata <= w_sel1 ? m1_wdata : m0_wdata;
                        r_cnt   <= '0;
                    end
                end
                S_ISSUE, S_WAIT: begin
                    if (w_done) begin
                        r_state <= S_IDLE;
                        r_grant <= 2'b00;
                    end else begin
                        r_state <= S_WAIT;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    assign transfer    = (r_state == S_ISSUE);
    assign write       = r_write;
    assign addr        = r_addr;
    assign wdata       = r_wdata;
    assign grant       = r_grant;
    assign timeout_err = w_timeout;

    assign m0_ready = w_done & r_grant[0];
    assign m1_ready = w_done & r_grant[1];
    assign m0_rdata = m0_ready ? w_resp : 32'h0;
    assign m1_rdata = m1_ready ? w_resp : 32'h0;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Bench for apb_bus_arbiter: random traffic against a transaction-level model,
// then directed fairness, capture, watchdog and reset scenarios.
module tb_apb_bus_arbiter;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        t_req   [2];
    logic        t_write [2];
    logic [31:0] t_addr  [2];
    logic [31:0] t_wdata [2];
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ready, m1_ready;
    logic        transfer, write;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_vec  = 0;
    int n_miss = 0;

    // transaction-level model state
    bit          m_busy, m_busy_next, m_xfer_now, m_xfer_next;
    bit          m_last, m_owner, done_prev, done_owner, completing;
    bit          s_active;
    int          s_cnt;
    logic        cap_write;
    logic [31:0] cap_addr, cap_wdata;

    apb_bus_arbiter #(.TIMEOUT_CYCLES(16), .ERR_RDATA(32'hDEAD_BEEF)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .m0_transfer(t_req[0]), .m0_write(t_write[0]), .m0_addr(t_addr[0]),
        .m0_wdata(t_wdata[0]), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_transfer(t_req[1]), .m1_write(t_write[1]), .m1_addr(t_addr[1]),
        .m1_wdata(t_wdata[1]), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .grant(grant), .timeout_err(timeout_err)
    );

    initial forever #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge PCLK);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            t_req[i] = 1'b0; t_write[i] = 1'b0; t_addr[i] = 32'h0; t_wdata[i] = 32'h0;
        end
        ready = 1'b0;
        rdata = 32'h0;
    endtask

    task automatic do_reset();
        PRESET = 1'b1;
        clear_inputs();
        repeat (2) @(posedge PCLK);
        #1;
        PRESET = 1'b0;
    endtask

    task automatic new_req(input int i);
        t_req[i]   = 1'b1;
        t_write[i] = 1'($urandom_range(1, 0));
        t_addr[i]  = $urandom;
        t_wdata[i] = $urandom;
    endtask

    initial begin
        clear_inputs();
        PRESET = 1'b1;
        #3;
        chk("rst_transfer", transfer, 0);
        chk("rst_grant", grant, 0);
        chk("rst_addr", addr, 0);
        chk("rst_write", write, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_m0_ready", m0_ready, 0);
        chk("rst_m1_ready", m1_ready, 0);
        chk("rst_timeout", timeout_err, 0);
        do_reset();

        // ---------------- randomized traffic ----------------
        m_busy_next = 0; m_xfer_next = 0; m_last = 1; m_owner = 0;
        done_prev = 0; done_owner = 0; s_active = 0; s_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc != 0) tick();
            m_busy     = m_busy_next;
            m_xfer_now = m_xfer_next;
            if (done_prev) begin
                if ($urandom_range(1, 0) == 1) new_req(int'(done_owner));
                else t_req[done_owner] = 1'b0;
                done_prev = 0;
            end
            for (int i = 0; i < 2; i++) begin
                if (!t_req[i] && $urandom_range(2, 0) == 0) new_req(i);
                else if (m_busy && int'(m_owner) == i && $urandom_range(3, 0) == 0) begin
                    t_addr[i]  = $urandom;
                    t_wdata[i] = $urandom;
                    t_write[i] = ~t_write[i];
                end
            end
            if (m_xfer_now) begin
                s_active = 1;
                s_cnt    = int'($urandom_range(3, 0));
            end
            rdata = $urandom;
            if (s_active && s_cnt == 0) ready = 1'b1;
            else ready = 1'(!m_busy && $urandom_range(7, 0) == 0);

            smp();
            completing = s_active && s_cnt == 0;
            chk("rnd_transfer", transfer, m_xfer_now);
            chk("rnd_grant", grant, m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
            chk("rnd_m0_ready", m0_ready, completing && !m_owner);
            chk("rnd_m1_ready", m1_ready, completing && m_owner);
            chk("rnd_m0_rdata", m0_rdata, (completing && !m_owner) ? rdata : 32'h0);
            chk("rnd_m1_rdata", m1_rdata, (completing && m_owner) ? rdata : 32'h0);
            chk("rnd_timeout", timeout_err, 0);
            if (m_busy) begin
                chk("rnd_addr", addr, cap_addr);
                chk("rnd_wdata", wdata, cap_wdata);
                chk("rnd_write", write, cap_write);
            end

            m_xfer_next = 0;
            if (m_busy) begin
                if (completing) begin
                    m_busy_next = 0; s_active = 0; done_prev = 1; done_owner = m_owner;
                end else begin
                    m_busy_next = 1; s_cnt = s_cnt - 1;
                end
            end else if (t_req[0] || t_req[1]) begin
                m_owner     = (t_req[0] && t_req[1]) ? !m_last : bit'(t_req[1]);
                m_last      = m_owner;
                cap_addr    = t_addr[m_owner];
                cap_wdata   = t_wdata[m_owner];
                cap_write   = t_write[m_owner];
                m_busy_next = 1;
                m_xfer_next = 1;
            end else begin
                m_busy_next = 0;
            end
        end

        // ---------------- strict alternation on a held tie ----------------
        do_reset();
        t_req[0] = 1; t_write[0] = 1; t_addr[0] = 32'h1000_1000; t_wdata[0] = 32'h55;
        t_req[1] = 1; t_write[1] = 1; t_addr[1] = 32'h1000_2000; t_wdata[1] = 32'hAA;
        for (int k = 0; k < 4; k++) begin
            tick();
            ready = 1; rdata = 32'h0;
            smp();
            chk("alt_transfer", transfer, 1);
            chk("alt_grant", grant, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("alt_addr", addr, (k % 2 == 1) ? 32'h1000_2000 : 32'h1000_1000);
            chk("alt_wdata", wdata, (k % 2 == 1) ? 32'hAA : 32'h55);
            chk("alt_owner_ready", (k % 2 == 1) ? m1_ready : m0_ready, 1);
            chk("alt_other_ready", (k % 2 == 1) ? m0_ready : m1_ready, 0);
            tick();
            ready = 0;
            smp();
            chk("alt_idle_grant", grant, 0);
            chk("alt_idle_transfer", transfer, 0);
        end

        // ---------------- registered capture ----------------
        do_reset();
        t_req[1] = 1; t_write[1] = 0; t_addr[1] = 32'h1000_2000;
        tick();
        tick();
        t_addr[1] = 32'h1000_3000;
        smp();
        chk("cap_addr_wait", addr, 32'h1000_2000);
        tick();
        ready = 1; rdata = 32'h0000_0042;
        smp();
        chk("cap_addr_done", addr, 32'h1000_2000);
        chk("cap_m1_ready", m1_ready, 1);
        chk("cap_m1_rdata", m1_rdata, 32'h42);
        tick();
        t_req[1] = 0; ready = 0;

        // ---------------- watchdog timeout and late ready ----------------
        do_reset();
        t_req[0] = 1; t_write[0] = 0; t_addr[0] = 32'h1000_0000;
        tick();
        smp();
        chk("to_issue_transfer", transfer, 1);
        repeat (15) tick();
        smp();
        chk("to_c15_m0_ready", m0_ready, 0);
        chk("to_c15_timeout", timeout_err, 0);
        tick();
        smp();
        chk("to_c16_m0_ready", m0_ready, 1);
        chk("to_c16_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("to_c16_timeout", timeout_err, 1);
        tick();
        t_req[0] = 0; ready = 1; rdata = 32'h77;
        smp();
        chk("to_late_m0_ready", m0_ready, 0);
        chk("to_late_m1_ready", m1_ready, 0);
        chk("to_late_m0_rdata", m0_rdata, 0);
        chk("to_late_grant", grant, 0);
        tick();
        ready = 0;

        // ---------------- ready coincident with timeout ----------------
        do_reset();
        t_req[0] = 1; t_write[0] = 0; t_addr[0] = 32'h1000_0000;
        tick();
        repeat (15) tick();
        tick();
        ready = 1; rdata = 32'h0000_1234;
        smp();
        chk("co_m0_ready", m0_ready, 1);
        chk("co_m0_rdata", m0_rdata, 32'h1234);
        chk("co_timeout", timeout_err, 0);
        tick();
        t_req[0] = 0; ready = 0;

        // ---------------- asynchronous reset during WAIT ----------------
        do_reset();
        t_req[0] = 1; t_write[0] = 1; t_addr[0] = 32'h1000_0000; t_wdata[0] = 32'h0000_00F0;
        tick();
        tick();
        smp();
        chk("rw_pre_addr", addr, 32'h1000_0000);
        chk("rw_pre_grant", grant, 2'b01);
        #2;
        PRESET = 1;
        #1;
        chk("rw_async_grant", grant, 0);
        chk("rw_async_addr", addr, 0);
        chk("rw_async_wdata", wdata, 0);
        chk("rw_async_write", write, 0);
        t_req[1] = 1; t_write[1] = 0; t_addr[1] = 32'h1000_2000;
        @(posedge PCLK);
        #2;
        PRESET = 0;
        tick();
        smp();
        chk("rw_after_transfer", transfer, 1);
        chk("rw_after_grant", grant, 2'b01);
        chk("rw_after_addr", addr, 32'h1000_0000);
        tick();
        ready = 1; rdata = 32'h0;
        smp();
        chk("rw_after_m0_ready", m0_ready, 1);
        tick();
        clear_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
